sif_recip_square_arb: RTL and testbench

Round-robin arbiter that shares one half-precision reciprocal-square unit (16-bit vld/rdy stream in, 16-bit vld/rdy stream out) between NUM_REQ requesters. It sits between the normalisation/attention lanes and the single `sif_recip_square_half_fp` instance. It issues one operand per cycle at most and tracks each in-flight operand's requester ID in a tag FIFO. Results return in order to the requester that issued them.

---
 rtl/sif_recip_square_arb.sv | 176 +++++++++++++++++
 tb/tb_sif_recip_square_arb.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sif_recip_square_arb.sv
// Round-robin arbiter sharing one fp16 reciprocal-square core between NUM_REQ
// requesters. Operands are issued at most one per cycle. The requester ID of every
// in-flight operand is kept in an in-order tag FIFO, so each result is routed back
// to the requester that issued it.
module sif_recip_square_arb #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DAT_W   = 16,
  parameter int unsigned MAX_OUT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  // requester side
  input  logic [NUM_REQ-1:0]         req_vld,
  input  logic [NUM_REQ*DAT_W-1:0]   req_dat,
  output logic [NUM_REQ-1:0]         req_rdy,
  output logic [NUM_REQ-1:0]         rsp_vld,
  output logic [DAT_W-1:0]           rsp_dat,
  input  logic [NUM_REQ-1:0]         rsp_rdy,
  // core side
  output logic                       core_A_vld,
  output logic [DAT_W-1:0]           core_A_dat,
  input  logic                       core_A_rdy,
  input  logic                       core_P_vld,
  input  logic [DAT_W-1:0]           core_P_dat,
  output logic                       core_P_rdy,
  // status
  output logic [$clog2(MAX_OUT):0]   outstanding,
  output logic                       orphan_err
);

  localparam int unsigned CntW = $clog2(MAX_OUT) + 1;
  localparam int unsigned PtrW = $clog2(MAX_OUT);
  localparam int unsigned TagW = $clog2(NUM_REQ);

  typedef enum logic [0:0] {StArb, StHold} state_e;

  state_e          state_q;
  logic [TagW-1:0] ptr_q;
  logic [TagW-1:0] hold_gnt_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [TagW-1:0] tag_mem_q [MAX_OUT];
  logic            orphan_q;

  logic            full, empty;
  logic            arb_hit;
  logic [TagW-1:0] arb_gnt;
  logic [TagW:0]   rr_sum;
  logic [TagW-1:0] rr_cand;
  logic [TagW-1:0] gnt;
  logic [TagW-1:0] gnt_next;
  logic [TagW-1:0] head;
  logic            issue, ret, orphan_set;

  // Occupancy flags come from the registered count only, so a return in the same
  // cycle cannot unblock an issue while full.
  always_comb begin
    full  = (cnt_q == CntW'(MAX_OUT));
    empty = (cnt_q == '0);
  end

  // Round-robin search: first valid requester at or above ptr_q, modulo NUM_REQ.
  always_comb begin
    arb_hit = 1'b0;
    arb_gnt = ptr_q;
    rr_sum  = '0;
    rr_cand = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      rr_sum = {1'b0, ptr_q} + (TagW + 1)'(k);
      if (rr_sum >= (TagW + 1)'(NUM_REQ)) begin
        rr_sum = rr_sum - (TagW + 1)'(NUM_REQ);
      end
      rr_cand = rr_sum[TagW-1:0];
      if (!arb_hit && req_vld[rr_cand]) begin
        arb_hit = 1'b1;
        arb_gnt = rr_cand;
      end
    end
  end

  // Issue path: a grant that stalls is frozen in HOLD so operand and valid stay stable.
  always_comb begin
    gnt        = (state_q == StHold) ? hold_gnt_q : arb_gnt;
    core_A_vld = 1'b0;
    if (!rst && !full) begin
      core_A_vld = (state_q == StHold) ? req_vld[hold_gnt_q] : arb_hit;
    end
    core_A_dat = req_dat[32'(gnt) * DAT_W +: DAT_W];
    req_rdy    = '0;
    if (core_A_vld) begin
      req_rdy[gnt] = core_A_rdy;
    end
    issue    = core_A_vld & core_A_rdy;
    gnt_next = (gnt == TagW'(NUM_REQ - 1)) ? '0 : gnt + TagW'(1);
  end

  // Return path: the FIFO head selects which requester sees the core result.
  // With no tag outstanding (or in reset) results are accepted and dropped.
  always_comb begin
    head    = tag_mem_q[rd_ptr_q];
    rsp_dat = core_P_dat;
    rsp_vld = '0;
    if (!rst && !empty) begin
      rsp_vld[head] = core_P_vld;
    end
    core_P_rdy = (rst || empty) ? 1'b1 : rsp_rdy[head];
    ret        = core_P_vld & core_P_rdy & ~empty & ~rst;
    orphan_set = core_P_vld & empty & ~rst;
  end

  // In-flight count: simultaneous issue and return cancel out.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({issue, ret})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Arbiter FSM, round-robin pointer, FIFO pointers, count and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StArb;
      ptr_q      <= '0;
      hold_gnt_q <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      orphan_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StArb: begin
          if (core_A_vld && !core_A_rdy) begin
            state_q    <= StHold;
            hold_gnt_q <= arb_gnt;
          end
        end
        StHold: begin
          // Leaving on a dropped valid keeps a misbehaving requester from wedging us.
          if (issue || !req_vld[hold_gnt_q]) begin
            state_q <= StArb;
          end
        end
        default: state_q <= StArb;
      endcase
      if (issue) begin
        ptr_q    <= gnt_next;
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (ret) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      cnt_q <= cnt_d;
      if (orphan_set) begin
        orphan_q <= 1'b1;
      end
    end
  end

  // Tag storage needs no reset; only entries between the pointers are meaningful.
  always_ff @(posedge clk) begin
    if (issue) begin
      tag_mem_q[wr_ptr_q] <= gnt;
    end
  end

  assign outstanding = cnt_q;
  assign orphan_err  = orphan_q;

  a_cnt_bound: assert property (@(posedge clk) disable iff (rst) cnt_q <= CntW'(MAX_OUT));
  a_no_issue_full: assert property (@(posedge clk) disable iff (rst) !(issue && full));
  a_req_rdy_1h: assert property (@(posedge clk) disable iff (rst) $onehot0(req_rdy));
  a_rsp_vld_1h: assert property (@(posedge clk) disable iff (rst) $onehot0(rsp_vld));

endmodule

// File: tb/tb_sif_recip_square_arb.sv
// Directed bench for sif_recip_square_arb with a small in-order core model that
// returns 1/x^2 for power-of-two fp16 operands one cycle after acceptance.
module tb_sif_recip_square_arb;

  localparam int NR = 4;
  localparam int DW = 16;
  localparam int MO = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_vld, req_rdy, rsp_vld, rsp_rdy;
  logic [NR*DW-1:0] req_dat;
  logic [DW-1:0]    rsp_dat, core_A_dat, core_P_dat;
  logic             core_A_vld, core_A_rdy, core_P_vld, core_P_rdy;
  logic [4:0]       outstanding;
  logic             orphan_err;

  int n_checks = 0;
  int n_errors = 0;

  sif_recip_square_arb #(
    .NUM_REQ(NR),
    .DAT_W  (DW),
    .MAX_OUT(MO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_vld    (req_vld),
    .req_dat    (req_dat),
    .req_rdy    (req_rdy),
    .rsp_vld    (rsp_vld),
    .rsp_dat    (rsp_dat),
    .rsp_rdy    (rsp_rdy),
    .core_A_vld (core_A_vld),
    .core_A_dat (core_A_dat),
    .core_A_rdy (core_A_rdy),
    .core_P_vld (core_P_vld),
    .core_P_dat (core_P_dat),
    .core_P_rdy (core_P_rdy),
    .outstanding(outstanding),
    .orphan_err (orphan_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // 1/x^2 of a power-of-two fp16: biased exponent e maps to 45 - 2e.
  function automatic logic [15:0] recip_sq(input logic [15:0] x);
    int r;
    r = 45 - 2 * int'(x[14:10]);
    return {1'b0, r[4:0], 10'b0};
  endfunction

  // Core model (no reset, like the real core).
  logic        core_en;
  logic [15:0] cq[$];
  int          cq_n = 0;
  logic [15:0] cq_head = '0;
  logic        cm_push, cm_pop;
  logic [15:0] cm_val;
  assign core_P_vld = core_en && (cq_n != 0);
  assign core_P_dat = cq_head;

  always @(posedge clk) begin
    cm_push = core_A_vld & core_A_rdy;
    cm_val  = core_A_dat;
    cm_pop  = core_P_vld & core_P_rdy;
    #1;
    if (cm_pop) void'(cq.pop_front());
    if (cm_push) cq.push_back(recip_sq(cm_val));
    cq_n    = cq.size();
    cq_head = (cq_n != 0) ? cq[0] : '0;
  end

  // Expected issue order and expected responses, filled by the test sequence.
  int          ei_id[$];
  logic [15:0] ei_dat[$];
  int          er_id[$];
  logic [15:0] er_dat[$];

  task automatic exp_iss(input int id, input logic [15:0] d);
    ei_id.push_back(id);
    ei_dat.push_back(d);
  endtask

  task automatic exp_rsp(input int id, input logic [15:0] d);
    er_id.push_back(id);
    er_dat.push_back(d);
  endtask

  // Issue and response monitors, sampled mid-cycle.
  always @(negedge clk) begin
    if (core_A_vld && core_A_rdy) begin
      check_val("iss_pending", 32'(ei_id.size() > 0), 32'd1);
      if (ei_id.size() > 0) begin
        check_val("iss_dat", 32'(core_A_dat), 32'(ei_dat[0]));
        check_val("iss_req_rdy", 32'(req_rdy), 32'(1 << ei_id[0]));
        void'(ei_id.pop_front());
        void'(ei_dat.pop_front());
      end
    end
    if (|rsp_vld) begin
      check_val("rsp_pending", 32'(er_id.size() > 0), 32'd1);
      if (er_id.size() > 0) begin
        check_val("rsp_route", 32'(rsp_vld), 32'(1 << er_id[0]));
        check_val("rsp_dat", 32'(rsp_dat), 32'(er_dat[0]));
        if (|(rsp_vld & rsp_rdy)) begin
          void'(er_id.pop_front());
          void'(er_dat.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dat(input int id, input logic [15:0] d);
    req_dat[id*DW +: DW] = d;
  endtask

  logic [15:0] op_tab[4];
  logic [15:0] res_tab[4];

  initial begin
    op_tab  = '{16'h3800, 16'h3C00, 16'h4000, 16'h4400};
    res_tab = '{16'h4400, 16'h3C00, 16'h3400, 16'h2C00};
    rst = 1'b1; req_vld = '1; req_dat = '0; rsp_rdy = '1; core_A_rdy = 1'b1; core_en = 1'b0;
    for (int i = 0; i < NR; i++) set_dat(i, op_tab[i]);

    // Reset behaviour
    @(negedge clk);
    check_val("rst_core_A_vld", 32'(core_A_vld), 32'd0);
    check_val("rst_req_rdy", 32'(req_rdy), 32'd0);
    check_val("rst_rsp_vld", 32'(rsp_vld), 32'd0);
    check_val("rst_core_P_rdy", 32'(core_P_rdy), 32'd1);
    tick();
    tick();
    rst = 1'b0; req_vld = '0;
    @(negedge clk);
    check_val("rst_outstanding", 32'(outstanding), 32'd0);
    check_val("rst_orphan", 32'(orphan_err), 32'd0);
    check_val("idle_core_A_vld", 32'(core_A_vld), 32'd0);

    // Single requester: 1.0 -> 1.0, 4.0 -> 1/16
    core_en = 1'b1;
    exp_iss(1, 16'h3C00); exp_iss(1, 16'h4400);
    exp_rsp(1, 16'h3C00); exp_rsp(1, 16'h2C00);
    tick();
    req_vld = 4'b0010; set_dat(1, 16'h3C00);
    @(negedge clk);
    check_val("t1_core_A_vld", 32'(core_A_vld), 32'd1);
    tick();
    set_dat(1, 16'h4400);
    @(negedge clk);
    check_val("t1_outstanding_1", 32'(outstanding), 32'd1);
    tick();
    req_vld = '0;
    repeat (4) tick();
    @(negedge clk);
    check_val("t1_outstanding_0", 32'(outstanding), 32'd0);
    check_val("t1_rsp_left", 32'(er_id.size()), 32'd0);

    // All four requesting from reset: grant order 0,1,2,3,0,1,2,3
    tick();
    rst = 1'b1;
    for (int i = 0; i < NR; i++) set_dat(i, op_tab[i]);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NR; i++) begin
        exp_iss(i, op_tab[i]);
        exp_rsp(i, res_tab[i]);
      end
    end
    tick();
    rst = 1'b0; req_vld = 4'b1111;
    repeat (8) tick();
    req_vld = '0;
    repeat (4) tick();
    @(negedge clk);
    check_val("t2_iss_left", 32'(ei_id.size()), 32'd0);
    check_val("t2_rsp_left", 32'(er_id.size()), 32'd0);
    check_val("t2_outstanding", 32'(outstanding), 32'd0);

    // Hold: move ptr to 1, then stall core with req 2 granted and req 0 waiting
    tick();
    req_vld = 4'b0001; set_dat(0, 16'h3800);
    exp_iss(0, 16'h3800); exp_rsp(0, 16'h4400);
    tick();
    req_vld = '0;
    repeat (3) tick();
    core_A_rdy = 1'b0; req_vld = 4'b0101;
    set_dat(2, 16'h4000); set_dat(1, 16'h3C00);
    @(negedge clk);
    check_val("t3_vld_stall", 32'(core_A_vld), 32'd1);
    check_val("t3_dat_stall", 32'(core_A_dat), 32'h4000);
    check_val("t3_req_rdy_stall", 32'(req_rdy), 32'd0);
    tick();
    req_vld = 4'b0111; // req 1 joins; an illegal re-arbitration from ptr=1 would pick it
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_val("t3_hold_dat", 32'(core_A_dat), 32'h4000);
      check_val("t3_hold_vld", 32'(core_A_vld), 32'd1);
      tick();
    end
    exp_iss(2, 16'h4000); exp_iss(0, 16'h3800); exp_iss(1, 16'h3C00);
    exp_rsp(2, 16'h3400); exp_rsp(0, 16'h4400); exp_rsp(1, 16'h3C00);
    core_A_rdy = 1'b1;
    repeat (3) tick();
    req_vld = '0;
    repeat (4) tick();
    @(negedge clk);
    check_val("t3_iss_left", 32'(ei_id.size()), 32'd0);
    check_val("t3_rsp_left", 32'(er_id.size()), 32'd0);

    // Full: return path blocked, exactly MAX_OUT issues
    tick();
    rsp_rdy = '0; req_vld = 4'b1000; set_dat(3, 16'h4400);
    for (int i = 0; i < MO; i++) exp_iss(3, 16'h4400);
    for (int i = 0; i < MO + 1; i++) exp_rsp(3, 16'h2C00);
    repeat (20) tick();
    @(negedge clk);
    check_val("t4_outstanding_full", 32'(outstanding), 32'd16);
    check_val("t4_full_vld", 32'(core_A_vld), 32'd0);
    check_val("t4_full_req_rdy", 32'(req_rdy), 32'd0);
    check_val("t4_issue_count", 32'(ei_id.size()), 32'd0);
    tick();
    rsp_rdy = 4'b1000;
    @(negedge clk);
    check_val("t4_ret_P_rdy", 32'(core_P_rdy), 32'd1);
    check_val("t4_same_cycle_vld", 32'(core_A_vld), 32'd0);
    tick();
    rsp_rdy = '0;
    exp_iss(3, 16'h4400);
    @(negedge clk);
    check_val("t4_after_ret_cnt", 32'(outstanding), 32'd15);
    check_val("t4_after_ret_vld", 32'(core_A_vld), 32'd1);
    tick();
    @(negedge clk);
    check_val("t4_refull_cnt", 32'(outstanding), 32'd16);
    check_val("t4_refull_vld", 32'(core_A_vld), 32'd0);
    tick();
    rsp_rdy = '1; req_vld = '0;
    repeat (24) tick();
    @(negedge clk);
    check_val("t4_drain_cnt", 32'(outstanding), 32'd0);
    check_val("t4_rsp_left", 32'(er_id.size()), 32'd0);

    // Reset with three operands in flight; their results become orphans
    tick();
    core_en = 1'b0; req_vld = 4'b0001; set_dat(0, 16'h3800);
    for (int i = 0; i < 3; i++) exp_iss(0, 16'h3800);
    repeat (3) tick();
    rst = 1'b1;
    @(negedge clk);
    check_val("t5_rst_core_A_vld", 32'(core_A_vld), 32'd0);
    check_val("t5_rst_req_rdy", 32'(req_rdy), 32'd0);
    check_val("t5_rst_P_rdy", 32'(core_P_rdy), 32'd1);
    tick();
    rst = 1'b0; req_vld = '0;
    @(negedge clk);
    check_val("t5_outstanding", 32'(outstanding), 32'd0);
    check_val("t5_orphan_clear", 32'(orphan_err), 32'd0);
    check_val("t5_stale_held", 32'(cq_n), 32'd3);
    tick();
    core_en = 1'b1;
    repeat (5) tick();
    @(negedge clk);
    check_val("t5_orphan_set", 32'(orphan_err), 32'd1);
    check_val("t5_stale_drained", 32'(cq_n), 32'd0);
    exp_iss(2, 16'h4000); exp_rsp(2, 16'h3400);
    tick();
    req_vld = 4'b0100; set_dat(2, 16'h4000);
    tick();
    req_vld = '0;
    repeat (3) tick();
    @(negedge clk);
    check_val("t5_new_cnt", 32'(outstanding), 32'd0);
    check_val("t5_iss_left", 32'(ei_id.size()), 32'd0);
    check_val("t5_rsp_left", 32'(er_id.size()), 32'd0);
    check_val("t5_orphan_sticky", 32'(orphan_err), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
